// File: rtl/cla64_seq_ctrl_pkg.sv
// Shared constants and state encoding for the 64-bit sequential CLA adder.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional subtract support is enabled by CLA64_SUB_EN.
package cla64_seq_ctrl_pkg;

  localparam int CLA_SLICE_W   = 16;
  localparam int CLA_NUM_BEATS = 4;
  localparam int OP_W          = CLA_SLICE_W * CLA_NUM_BEATS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla64_seq_ctrl_if.sv
// Operand/result handshake bundle for cla64_seq_ctrl.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; ovf exists only with CLA64_SUB_EN.
interface cla64_seq_ctrl_if;

  logic                                 in_valid;
  logic                                 in_ready;
  logic [cla64_seq_ctrl_pkg::OP_W-1:0]  a;
  logic [cla64_seq_ctrl_pkg::OP_W-1:0]  b;
  logic                                 cin;
  logic                                 sub;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [cla64_seq_ctrl_pkg::OP_W-1:0]  sum;
  logic                                 cout;
  logic                                 gp;
  logic                                 gg;
`ifdef CLA64_SUB_EN
  logic                                 ovf;
`endif

  // Requester side: drives operands and consumes results.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, gp, gg
`ifdef CLA64_SUB_EN
    , input ovf
`endif
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, gp, gg
`ifdef CLA64_SUB_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/cla64_seq_ctrl_cla16.sv
// 16-bit carry-lookahead slice: 4-bit groups with lookahead across groups.
// Latency: purely combinational.
// Backpressure: none; also exports slice propagate/generate for folding.
module cla64_seq_ctrl_cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        p,
  output logic        g
);

  logic [15:0] pb;
  logic [15:0] gb;
  logic [3:0]  grp_p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_c;
  logic [15:0] c;

  // Bit and group propagate/generate, group carries by lookahead, then sums.
  always_comb begin
    pb = a ^ b;
    gb = a & b;
    for (int j = 0; j < 4; j++) begin
      grp_p[j] = &pb[4*j +: 4];
      grp_g[j] = gb[4*j+3]
               | (pb[4*j+3] & gb[4*j+2])
               | (pb[4*j+3] & pb[4*j+2] & gb[4*j+1])
               | (pb[4*j+3] & pb[4*j+2] & pb[4*j+1] & gb[4*j]);
    end
    grp_c[0] = cin;
    grp_c[1] = grp_g[0] | (grp_p[0] & cin);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
    g = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
      | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
    p = &grp_p;
    cout = g | (p & cin);
    c = '0;
    for (int j = 0; j < 4; j++) begin
      c[4*j] = grp_c[j];
      for (int k = 1; k < 4; k++) begin
        c[4*j+k] = gb[4*j+k-1] | (pb[4*j+k-1] & c[4*j+k-1]);
      end
    end
    sum = pb ^ c;
  end

endmodule

// File: rtl/cla64_seq_ctrl.sv
// 64-bit adder that time-multiplexes one 16-bit CLA slice over four beats.
// Latency: out_valid 5 edges after acceptance (capture + 4 beats); 1 op / 5 cycles.
// Backpressure: result held in DONE until out_ready; CLA64_SUB_EN adds subtract + ovf.
module cla64_seq_ctrl
  import cla64_seq_ctrl_pkg::*;
#(
  parameter int SLICE_W   = CLA_SLICE_W,
  parameter int NUM_BEATS = CLA_NUM_BEATS
) (
  input logic              clk,
  input logic              rst_n,
  cla64_seq_ctrl_if.slave  bus
);

  localparam int BEAT_W = $clog2(NUM_BEATS);
  localparam int W      = SLICE_W * NUM_BEATS;

  state_t              state;
  state_t              state_nxt;
  logic [BEAT_W-1:0]   beat;
  logic [W-1:0]        op_a;
  logic [W-1:0]        op_b;
  logic [W-1:0]        sum_r;
  logic                carry;
  logic                cout_r;
  logic                gp_r;
  logic                gg_r;
  logic                accept;
  logic                last_beat;
  logic                in_ready_c;
  logic [SLICE_W-1:0]  sl_a;
  logic [SLICE_W-1:0]  sl_b;
  logic [SLICE_W-1:0]  sl_sum;
  logic                sl_cout;
  logic                sl_p;
  logic                sl_g;
  logic                b_inv;
  logic                cin_eff;
`ifdef CLA64_SUB_EN
  logic                ovf_r;
`endif

  assign accept    = bus.in_valid && in_ready_c;
  assign last_beat = (beat == BEAT_W'(NUM_BEATS - 1));
  assign sl_a      = op_a[beat*SLICE_W +: SLICE_W];
  assign sl_b      = op_b[beat*SLICE_W +: SLICE_W];

`ifdef CLA64_SUB_EN
  // Subtraction is a + ~b + 1, so inversion and forced carry happen at capture.
  assign b_inv   = bus.sub;
  assign cin_eff = bus.cin | bus.sub;
  assign bus.ovf = ovf_r;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_inv      = 1'b0;
  assign cin_eff    = bus.cin;
`endif

  cla64_seq_ctrl_cla16 cla_16bit (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout),
    .p    (sl_p),
    .g    (sl_g)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    in_ready_c    = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (last_beat) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        in_ready_c    = bus.out_ready;
        if (bus.out_ready) state_nxt = bus.in_valid ? ST_BUSY : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.in_ready = in_ready_c;

  // Operand capture, per-beat result write-back, carry chaining and gp/gg folding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      gp_r   <= 1'b0;
      gg_r   <= 1'b0;
`ifdef CLA64_SUB_EN
      ovf_r  <= 1'b0;
`endif
    end else if (accept) begin
      op_a  <= bus.a;
      op_b  <= b_inv ? ~bus.b : bus.b;
      carry <= cin_eff;
      beat  <= '0;
    end else if (state == ST_BUSY) begin
      sum_r[beat*SLICE_W +: SLICE_W] <= sl_sum;
      carry <= sl_cout;
      // Folding low-to-high equals the slice-3-down-to-0 lookahead combine.
      if (beat == '0) begin
        gp_r <= sl_p;
        gg_r <= sl_g;
      end else begin
        gp_r <= gp_r & sl_p;
        gg_r <= sl_g | (sl_p & gg_r);
      end
      if (last_beat) begin
        cout_r <= sl_cout;
`ifdef CLA64_SUB_EN
        ovf_r  <= (op_a[W-1] == op_b[W-1]) && (sl_sum[SLICE_W-1] != op_a[W-1]);
`endif
      end
      beat <= beat + 1'b1;
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.gp   = gp_r;
  assign bus.gg   = gg_r;

endmodule

// File: tb/tb_cla64_seq_ctrl.sv
// Self-checking bench for cla64_seq_ctrl: vector table, scoreboard, corner sequences.
// Latency: checks out_valid arrives on the 5th edge counting the accepting edge.
// Backpressure: holds out_ready low in DONE; honours CLA64_SUB_EN for subtract cases.
module tb_cla64_seq_ctrl;
  import cla64_seq_ctrl_pkg::*;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        gp;
    logic        gg;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        gp;
    logic        gg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  cla64_seq_ctrl_if bus ();

  cla64_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Whole-word reference: gp means every bit propagates, gg is the carry-out with cin=0.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic c);
    logic [64:0] s;
    logic [64:0] s0;
    exp_t        e;
    s      = {1'b0, a} + {1'b0, b} + {64'd0, c};
    s0     = {1'b0, a} + {1'b0, b};
    e.sum  = s[63:0];
    e.cout = s[64];
    e.gp   = &(a ^ b);
    e.gg   = s0[64];
    return e;
  endfunction

  // Called at a negedge; returns just after the accepting edge.
  task automatic accept_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                           input logic s, input exp_t e);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    chk("in_ready_at_accept", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    sb.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = {$urandom, $urandom};
    bus.b        = {$urandom, $urandom};
    bus.cin      = 1'($urandom);
  endtask

  // Waits (bounded) for out_valid, checks latency, pops and compares the scoreboard.
  task automatic wait_result(input string name);
    int   lat;
    exp_t e;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk({name, "_latency"}, 64'(lat), 64'd5);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_sum"},  bus.sum, e.sum);
      chk({name, "_cout"}, {63'd0, bus.cout}, {63'd0, e.cout});
      chk({name, "_gp"},   {63'd0, bus.gp},   {63'd0, e.gp});
      chk({name, "_gg"},   {63'd0, bus.gg},   {63'd0, e.gg});
    end
  endtask

  // Lets the held result transfer (out_ready=1, in_valid=0) and checks return to idle.
  task automatic finish_op(input string name);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_idle_valid"}, {63'd0, bus.out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    exp_t e;
    logic seen;
    logic [63:0] held;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
                64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_sum",       bus.sum,                64'd0);
    chk("rst_cout",      {63'd0, bus.cout},      64'd0);
    chk("rst_gp",        {63'd0, bus.gp},        64'd0);
    chk("rst_gg",        {63'd0, bus.gg},        64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      accept_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
                '{vecs[i].sum, vecs[i].cout, vecs[i].gp, vecs[i].gg});
      wait_result($sformatf("vec%0d", i));
      finish_op($sformatf("vec%0d", i));
    end

    // Random operands against the whole-word model.
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      if (i == 0) rb = ~ra;
      accept_op(ra, rb, rc, 1'b0, model(ra, rb, rc));
      wait_result($sformatf("rnd%0d", i));
      finish_op($sformatf("rnd%0d", i));
    end

    // Reset during beat 2 discards the operation.
    accept_op(64'h1, 64'h1, 1'b0, 1'b0, model(64'h1, 64'h1, 1'b0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_sum",       bus.sum,                64'd0);
    chk("midrst_flags",     {61'd0, bus.cout, bus.gp, bus.gg}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    chk("midrst_no_valid", {63'd0, seen}, 64'd0);

    // Backpressure: result and in_ready held while out_ready is low; in_valid ignored.
    bus.out_ready = 1'b0;
    accept_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
              '{64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 1'b0});
    wait_result("bp");
    held = bus.sum;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_sum", i), bus.sum, 64'h2345_6789_ABCD_F001);
      chk($sformatf("bp_hold%0d_in_ready", i), {63'd0, bus.in_ready}, 64'd0);
      chk($sformatf("bp_hold%0d_out_valid", i), {63'd0, bus.out_valid}, 64'd1);
    end
    chk("bp_held_vs_first", bus.sum, held);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    finish_op("bp");

    // Back-to-back: new operands accepted on the same edge the result transfers.
    accept_op(64'd100, 64'd23, 1'b0, 1'b0, '{64'd123, 1'b0, 1'b0, 1'b0});
    wait_result("b2b_first");
    accept_op(64'd5, 64'd7, 1'b0, 1'b0, '{64'd12, 1'b0, 1'b0, 1'b0});
    wait_result("b2b_second");
    finish_op("b2b");

`ifdef CLA64_SUB_EN
    accept_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
              '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1});
    wait_result("sub_ovf");
    chk("sub_ovf_flag", {63'd0, bus.ovf}, 64'd1);
    finish_op("sub_ovf");
    e = model(64'd5, ~64'd3, 1'b1);
    accept_op(64'd5, 64'd3, 1'b0, 1'b1, e);
    wait_result("sub_small");
    chk("sub_small_flag", {63'd0, bus.ovf}, 64'd0);
    finish_op("sub_small");
`else
    accept_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
              '{64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b0});
    wait_result("sub_ignored");
    finish_op("sub_ignored");
    e = model(64'd5, 64'd3, 1'b0);
    accept_op(64'd5, 64'd3, 1'b0, 1'b1, e);
    wait_result("sub_ignored2");
    finish_op("sub_ignored2");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
